fp_add_arb: RTL

FP_ADD_ARB -- requirements
Module: fp_add_arb

---
 rtl/fp_add_arb.sv | 65 ++++++
 1 files changed

// File: rtl/fp_add_arb.sv
// fp_add_arb: round-robin arbiter sharing one fixed-latency FP adder between two requesters
module fp_add_arb #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req0_sub,
  input  logic        req1_sub,
  input  logic        hold,
  output logic        add_en,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_sub,
  input  logic [31:0] add_res,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [3:0]  inflight
);
  logic           rr;
  logic           issue;
  logic           gnt1;
  logic [LAT-1:0] tag_valid;
  logic [LAT-1:0] tag_id;
  always_comb begin
    issue      = (req0_valid | req1_valid) & ~hold & ~reset;
    gnt1       = req1_valid & (~req0_valid | rr);
    req0_ready = issue & ~gnt1;
    req1_ready = issue & gnt1;
    add_en     = issue;
    add_a      = issue ? (gnt1 ? req1_a : req0_a) : '0;
    add_b      = issue ? (gnt1 ? req1_b : req0_b) : '0;
    add_sub    = issue & (gnt1 ? req1_sub : req0_sub);
    busy       = (inflight != '0) & ~reset;
  end
  // tag pipe tracks which requester owns the result emerging from the adder
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid  <= '0;
      tag_id     <= '0;
      rr         <= 1'b0;
      inflight   <= '0;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      tag_valid  <= LAT'({tag_valid, issue});
      tag_id     <= LAT'({tag_id, gnt1});
      if (issue) rr <= ~gnt1;
      if (tag_valid[LAT-1]) rsp_data <= add_res;
      rsp0_valid <= tag_valid[LAT-1] & ~tag_id[LAT-1];
      rsp1_valid <= tag_valid[LAT-1] & tag_id[LAT-1];
      inflight   <= inflight + 4'(issue) - 4'(rsp0_valid | rsp1_valid);
    end
  end
endmodule
